// File: rtl/mmh_bank_mac.sv
// MMH inner-product engine: streams N_WORDS addresses to the sample banks and key store,
// multiplies 16 aligned lanes per word and accumulates the exact, unreduced sum.

module mmh_lane_mul #(
   parameter int DW = 64
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [DW-1:0]   i_a,
   input  logic [DW-1:0]   i_b,
   output logic [2*DW-1:0] o_p
);
   logic [2*DW-1:0] w_a, w_b;

   assign w_a = {{DW{1'b0}}, i_a};
   assign w_b = {{DW{1'b0}}, i_b};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) o_p <= '0;
      else     o_p <= w_a * w_b;
   end
endmodule

module mmh_bank_mac #(
   parameter int DATA_WIDTH = 64,
   parameter int LANES      = 16,
   parameter int ADDR_W     = 12,
   parameter int N_WORDS    = 4096,
   parameter int ACC_W      = 2*DATA_WIDTH + 4 + ADDR_W
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        hold,
   output logic [ADDR_W-1:0]           bank_addr,
   input  logic [LANES*DATA_WIDTH-1:0] bank_rd_data,
   input  logic [LANES*DATA_WIDTH-1:0] key_rd_data,
   output logic                        busy,
   output logic                        done,
   output logic [ACC_W-1:0]            hash
);
   localparam int DW    = DATA_WIDTH;
   localparam int SUM_W = 2*DW + 4;

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   state_t                          r_state, w_next;
   logic [ADDR_W-1:0]               r_addr;
   logic [2:0]                      r_vld_pipe;
   logic [LANES-1:0][2*DW-1:0]      w_prod;
   logic [SUM_W-1:0]                w_sum, r_sum;
   logic [ACC_W-1:0]                r_acc;
   logic                            w_issue, w_last, w_start_ok;

   assign w_issue    = (r_state == S_ISSUE) && !hold;
   assign w_last     = (r_addr == ADDR_W'(N_WORDS-1));
   assign w_start_ok = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (start) w_next = S_ISSUE;
         S_ISSUE: if (w_issue && w_last) w_next = S_DRAIN;
         // stage 2 still holds the last lane sum; it lands in acc on this same edge
         S_DRAIN: if (!r_vld_pipe[0] && !r_vld_pipe[1]) w_next = S_DONE;
         S_DONE:  w_next = start ? S_ISSUE : S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;
   end

   // address register doubles as the issue counter; it parks on the last address
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                     r_addr <= '0;
      else if (w_start_ok)         r_addr <= '0;
      else if (w_issue && !w_last) r_addr <= r_addr + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_vld_pipe <= '0;
      else     r_vld_pipe <= {r_vld_pipe[1:0], w_issue};
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      mmh_lane_mul #(.DW(DW)) u_mul (
         .clk (clk),
         .rst (rst),
         .i_a (bank_rd_data[g*DW +: DW]),
         .i_b (key_rd_data[g*DW +: DW]),
         .o_p (w_prod[g])
      );
   end

   always_comb begin
      w_sum = '0;
      for (int i = 0; i < LANES; i++) w_sum = w_sum + SUM_W'(w_prod[i]);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_sum <= '0;
      else     r_sum <= w_sum;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                r_acc <= '0;
      else if (w_start_ok)    r_acc <= '0;
      else if (r_vld_pipe[2]) r_acc <= r_acc + ACC_W'(r_sum);
   end

   assign bank_addr = r_addr;
   assign busy      = (r_state == S_ISSUE) || (r_state == S_DRAIN);
   assign done      = (r_state == S_DONE);
   assign hash      = r_acc;
endmodule

// File: tb/tb_mmh_bank_mac.sv
// Directed bench for mmh_bank_mac with N_WORDS=4 and a 1-cycle-latency memory model.

module tb_mmh_bank_mac;
   localparam int DW    = 64;
   localparam int LN    = 16;
   localparam int AW    = 12;
   localparam int NW    = 4;
   localparam int ACC_W = 2*DW + 4 + AW;

   logic              clk, rst, start, hold;
   logic [AW-1:0]     bank_addr;
   logic [LN*DW-1:0]  bank_rd_data, key_rd_data;
   logic              busy, done;
   logic [ACC_W-1:0]  hash;

   int n_tot  = 0;
   int n_fail = 0;
   int mode   = 0;
   int dc;
   logic [ACC_W-1:0] exp_max;

   mmh_bank_mac #(.DATA_WIDTH(DW), .LANES(LN), .ADDR_W(AW), .N_WORDS(NW)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .hold         (hold),
      .bank_addr    (bank_addr),
      .bank_rd_data (bank_rd_data),
      .key_rd_data  (key_rd_data),
      .busy         (busy),
      .done         (done),
      .hash         (hash)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   // sample banks and key store: registered read, one cycle after address
   initial begin
      bank_rd_data = '0;
      key_rd_data  = '0;
   end
   always @(posedge clk) begin
      for (int i = 0; i < LN; i++) begin
         case (mode)
            0: begin bank_rd_data[i*DW +: DW] <= 64'd1; key_rd_data[i*DW +: DW] <= 64'd1; end
            1: begin bank_rd_data[i*DW +: DW] <= '1;    key_rd_data[i*DW +: DW] <= '1;    end
            2: begin
               bank_rd_data[i*DW +: DW] <= 64'(i);
               key_rd_data[i*DW +: DW]  <= 64'(bank_addr) + 64'd1;
            end
            default: begin
               bank_rd_data[i*DW +: DW] <= 64'(i + 1);
               key_rd_data[i*DW +: DW]  <= 64'(i + 1) * (64'(bank_addr) + 64'd1);
            end
         endcase
      end
   end

   task automatic chk(input string tag, input logic [ACC_W-1:0] obs, input logic [ACC_W-1:0] exp);
      n_tot++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // leaves the bench at the negedge of cycle 1 after the start edge
   task automatic kick();
      @(negedge clk); start = 1;
      @(negedge clk); start = 0;
   endtask

   task automatic wait_done(input int hs, input int hl, input int bs, output int dcyc);
      int cyc = 1;
      dcyc = -1;
      while (cyc < 64) begin
         if (done) begin dcyc = cyc; break; end
         hold  = (cyc >= hs && cyc < hs + hl);
         start = (cyc == bs);
         if (hl > 0 && cyc == hs + hl - 1) chk("hold_addr_frozen", bank_addr, ACC_W'(hs - 1));
         @(negedge clk); cyc++;
      end
      hold  = 0;
      start = 0;
   endtask

   initial begin
      exp_max = (ACC_W'(1) << 134) - (ACC_W'(1) << 71) + ACC_W'(64);
      rst = 1; start = 0; hold = 0;
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_hash", hash, 0);
      chk("reset_addr", bank_addr, 0);
      rst = 0;

      // ones: 4 words x 16 lanes
      mode = 0;
      kick();
      chk("run1_busy_c1", busy, 1);
      chk("run1_addr_c1", bank_addr, 0);
      chk("run1_hash_c1", hash, 0);
      wait_done(0, 0, 0, dc);
      chk("run1_done_cycle", ACC_W'(dc), 8);
      chk("run1_hash", hash, 64);
      chk("run1_busy_done", busy, 0);
      chk("run1_addr_after", bank_addr, 3);
      @(negedge clk);
      chk("run1_done_pulse", done, 0);

      // all-ones operands: no truncation
      mode = 1;
      kick();
      wait_done(0, 0, 0, dc);
      chk("max_done_cycle", ACC_W'(dc), 8);
      chk("max_hash", hash, exp_max);

      mode = 2;
      kick();
      wait_done(0, 0, 0, dc);
      chk("lane_i_hash", hash, 1200);

      // per-lane distinct keys catch lane misalignment
      mode = 3;
      kick();
      wait_done(0, 0, 0, dc);
      chk("lane_sq_hash", hash, 14960);

      // hold for cycles 2..4
      mode = 0;
      kick();
      wait_done(2, 3, 0, dc);
      chk("hold_done_cycle", ACC_W'(dc), 11);
      chk("hold_hash", hash, 64);

      // start pulsed while busy is ignored
      kick();
      wait_done(0, 0, 3, dc);
      chk("busy_start_done_cycle", ACC_W'(dc), 8);
      chk("busy_start_hash", hash, 64);
      @(negedge clk);
      chk("busy_start_no_second_done", done, 0);
      chk("busy_start_idle", busy, 0);

      // start in DONE restarts directly with acc cleared
      mode = 2;
      kick();
      wait_done(0, 0, 0, dc);
      chk("pre_restart_hash", hash, 1200);
      start = 1;
      @(negedge clk); start = 0;
      chk("restart_hash_clear", hash, 0);
      chk("restart_busy", busy, 1);
      wait_done(0, 0, 0, dc);
      chk("restart_done_cycle", ACC_W'(dc), 8);
      chk("restart_hash", hash, 1200);

      // reset in the middle of a run
      mode = 0;
      kick();
      repeat (6) @(negedge clk);
      chk("abort_partial_hash", hash, 48);
      rst = 1;
      #1;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_hash", hash, 0);
      chk("abort_addr", bank_addr, 0);
      @(negedge clk); rst = 0;
      kick();
      wait_done(0, 0, 0, dc);
      chk("post_abort_done_cycle", ACC_W'(dc), 8);
      chk("post_abort_hash", hash, 64);

      $display("%0d/%0d checks passed", n_tot - n_fail, n_tot);
      $finish;
   end
endmodule
